// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter with a 4-entry byte FIFO.
// Word map from BASE_ADDR: +0 TXDATA (write), +1 STATUS, +2 BAUD_DIV.
module uart_tx_port #(
    parameter logic [8:0]  BASE_ADDR  = 9'h1F0,
    parameter logic [15:0] BAUD_RESET = 16'd433,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_write,
    input  logic [8:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        tx,
    output logic        busy
);

    localparam logic [8:0] ADDR_TXDATA = BASE_ADDR;
    localparam logic [8:0] ADDR_STATUS = BASE_ADDR + 9'd1;
    localparam logic [8:0] ADDR_BAUD   = BASE_ADDR + 9'd2;
    localparam logic [2:0] FULL_COUNT  = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_next;
    logic [15:0] baud_div;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        overflow;
    logic        empty, full, bit_end, pop, push;
    logic        wr_txdata, wr_status, wr_baud;
    logic [15:0] status;

    assign empty     = (count == 3'd0);
    assign full      = (count == FULL_COUNT);
    assign bit_end   = (bit_cnt == 16'd0);
    assign wr_txdata = read_write && (addr == ADDR_TXDATA);
    assign wr_status = read_write && (addr == ADDR_STATUS);
    assign wr_baud   = read_write && (addr == ADDR_BAUD);
    // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
    assign push      = wr_txdata && (!full || pop);
    assign busy      = (state != IDLE) || !empty;
    assign status    = {9'b0, overflow, count, empty, full, busy};

    always_comb begin
        data_out = 16'h0000;
        if (!read_write) begin
            if (addr == ADDR_STATUS)
                data_out = status;
            else if (addr == ADDR_BAUD)
                data_out = baud_div;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end)
                    state_next = DATA;
            end
            DATA: begin
                tx = shift[0];
                if (bit_end && (bit_idx == 3'd7))
                    state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timer reloads from baud_div only at a bit boundary, so a divider
    // change never shortens the bit in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
        end else if (pop) begin
            bit_cnt <= baud_div;
            bit_idx <= 3'd0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                bit_cnt <= baud_div;
                if (state == DATA)
                    bit_idx <= bit_idx + 3'd1;
            end else begin
                bit_cnt <= bit_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= data_in[7:0];
        if (pop)
            shift <= fifo_mem[rd_ptr];
        else if ((state == DATA) && bit_end)
            shift <= {1'b0, shift[7:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
            baud_div <= BAUD_RESET;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (wr_txdata && full && !pop)
                overflow <= 1'b1;
            else if (wr_status && data_in[6])
                overflow <= 1'b0;
            if (wr_baud)
                baud_div <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a line-level UART receiver model decodes tx and
// scores every frame against a queue of bytes the stimulus expects to see.
module tb_uart_tx_port;

    localparam logic [8:0] A_TX = 9'h1F0;
    localparam logic [8:0] A_ST = 9'h1F1;
    localparam logic [8:0] A_BD = 9'h1F2;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_write;
    logic [8:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        tx;
    logic        busy;

    uart_tx_port dut (
        .clk        (clk),
        .reset      (reset),
        .read_write (read_write),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         bit_len = 434;
    bit         mon_en = 1'b0;
    int         written = 0;
    int         started = 0;
    logic [7:0] exp_q[$];
    int         start_times[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic bus_write(input logic [8:0] a, input logic [15:0] d);
        read_write = 1'b1;
        addr       = a;
        data_in    = d;
        @(negedge clk);
        read_write = 1'b0;
        data_in    = 16'h0000;
    endtask

    task automatic bus_read(input logic [8:0] a, output logic [15:0] d);
        read_write = 1'b0;
        addr       = a;
        #1;
        d = data_out;
    endtask

    task automatic check_reg(input string name, input logic [8:0] a, input logic [15:0] req);
        logic [15:0] d;
        bus_read(a, d);
        check(name, d, req);
    endtask

    task automatic set_baud(input int v);
        bus_write(A_BD, 16'(v));
        bit_len = v + 1;
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        written++;
        bus_write(A_TX, {8'($urandom), b});
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    // Receiver model: every bit must hold one level for bit_len samples.
    initial begin : monitor
        int         blen;
        logic [9:0] bits;
        logic       ok;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx === 1'b0) begin
                blen = bit_len;
                started++;
                start_times.push_back(cyc);
                ok = 1'b1;
                bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < blen; c++) begin
                        if (!(b == 0 && c == 0))
                            @(negedge clk);
                        if (c == 0)
                            bits[b] = tx;
                        else if (tx !== bits[b])
                            ok = 1'b0;
                    end
                end
                check("frame_shape", {29'b0, ok, bits[0], bits[9]}, 32'h5);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame_byte: got unexpected frame 0x%0h, expected none", bits[8:1]);
                end else begin
                    want = exp_q.pop_front();
                    check("frame_byte", bits[8:1], want);
                end
            end
        end
    end

    initial begin : stimulus
        int   n;
        int   target;
        int   idx;
        int   first_bad;
        int   lens[10];
        logic samp[32];
        logic exp_s[32];
        logic bitv;

        reset      = 1'b1;
        read_write = 1'b0;
        addr       = 9'h000;
        data_in    = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        bus_write(A_BD, 16'd5);
        bus_write(A_TX, 16'h00A5);
        reset = 1'b0;
        check_reg("status_reset", A_ST, 16'h0004);
        check_reg("baud_reset", A_BD, 16'd433);
        check_reg("unmapped_read", 9'h1F3, 16'h0000);
        check_reg("txdata_read", A_TX, 16'h0000);
        read_write = 1'b1;
        addr       = A_ST;
        data_in    = 16'h0000;
        #1;
        check("read_during_write", data_out, 16'h0000);
        @(negedge clk);
        read_write = 1'b0;
        repeat (5) @(negedge clk);
        check("no_frame_from_reset_write", tx, 1'b1);
        check_reg("status_idle", A_ST, 16'h0004);
        mon_en = 1'b1;

        // Single frame at 4 cycles/bit with write-to-start latency
        set_baud(3);
        check_reg("baud_readback", A_BD, 16'd3);
        exp_q.push_back(8'h55);
        read_write = 1'b1;
        addr       = A_TX;
        data_in    = 16'hAB55;
        @(posedge clk);
        #1;
        read_write = 1'b0;
        check("latency_edge_n_tx", tx, 1'b1);
        check("busy_after_write", busy, 1'b1);
        @(posedge clk);
        #1;
        check("latency_edge_n1_tx", tx, 1'b0);
        @(negedge clk);
        drain("frame_55", 300);
        check_reg("status_after_frame", A_ST, 16'h0004);

        // Back-to-back frames at 1 cycle/bit
        set_baud(0);
        start_times.delete();
        send(8'h01);
        send(8'h02);
        drain("b2b", 200);
        check("b2b_frames", start_times.size(), 2);
        if (start_times.size() == 2)
            check("b2b_gap", start_times[1] - start_times[0], 10);

        // Overflow, overflow clear, and a full-FIFO write on a pop edge
        set_baud(7);
        start_times.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                exp_q.push_back(8'(8'hC0 + i));
            bus_write(A_TX, 16'(16'h3C0 + i));
        end
        check_reg("status_overflow", A_ST, 16'h0063);
        bus_write(A_ST, 16'h0040);
        check_reg("status_ovf_cleared", A_ST, 16'h0023);
        check("ovf_first_started", start_times.size(), 1);
        if (start_times.size() >= 1) begin
            target = start_times[0] + 79;
            while (cyc < target)
                @(negedge clk);
            exp_q.push_back(8'h5A);
            bus_write(A_TX, 16'h005A);
            check_reg("status_pop_edge_write", A_ST, 16'h0023);
        end
        drain("ovf_frames", 1200);
        check("ovf_frame_count", start_times.size(), 6);
        check_reg("status_after_ovf", A_ST, 16'h0004);

        // Divider change 3 -> 1 while data bit 2 is on the line
        mon_en = 1'b0;
        set_baud(3);
        bus_write(A_TX, 16'h0055);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 32; i++) begin
            if (i > 0)
                @(negedge clk);
            samp[i] = tx;
            if (i == 12) begin
                read_write = 1'b1;
                addr       = A_BD;
                data_in    = 16'd1;
            end else if (i == 13) begin
                read_write = 1'b0;
            end
        end
        lens = '{4, 4, 4, 4, 2, 2, 2, 2, 2, 2};
        idx  = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)
                bitv = 1'b0;
            else if (k == 9)
                bitv = 1'b1;
            else
                bitv = 1'((8'h55 >> (k - 1)) & 8'h01);
            for (int c = 0; c < lens[k]; c++) begin
                exp_s[idx] = bitv;
                idx++;
            end
        end
        for (int i = idx; i < 32; i++)
            exp_s[i] = 1'b1;
        first_bad = -1;
        for (int i = 0; i < 32; i++)
            if (first_bad < 0 && samp[i] !== exp_s[i])
                first_bad = i;
        check("baud_change_wave_first_bad_sample", first_bad, -1);
        repeat (3) @(negedge clk);
        check("baud_change_idle", busy, 1'b0);
        check_reg("baud_change_readback", A_BD, 16'd1);

        // Reset pulse during data bit 3 with a second byte still queued
        set_baud(3);
        bus_write(A_TX, 16'h0000);
        bus_write(A_TX, 16'h0000);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(negedge clk);
        check("pre_reset_bit3", tx, 1'b0);
        reset = 1'b1;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check_reg("status_after_abort", A_ST, 16'h0004);
        check_reg("baud_after_abort", A_BD, 16'd433);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1)
                n++;
        end
        check("no_residual_frame_low_samples", n, 0);

        // Randomized traffic, throttled so the FIFO can never overflow
        mon_en  = 1'b1;
        written = 0;
        started = 0;
        for (int r = 0; r < 4; r++) begin
            set_baud(int'($urandom_range(0, 3)));
            for (int k = 0; k < 10; k++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                n = 0;
                while ((written - started) >= 4 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                send(8'($urandom));
            end
            drain("random", 3000);
            check_reg("random_status", A_ST, 16'h0004);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
